// File: rtl/axi_dma_pkg.sv
// axi_dma_pkg: FSM states, AXI constants and strobe/4 KB helpers shared by the DMA engines
package axi_dma_pkg;
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_CALC, S_AW, S_W, S_B, S_DONE} state_t;
    localparam logic [2:0] SIZE_4B = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    function automatic logic [3:0] first_mask(input logic [1:0] off);
        return 4'b1111 << off;
    endfunction
    function automatic logic [3:0] last_mask(input logic [1:0] e);
        return e == 2'd0 ? 4'b1111 : ~(4'b1111 << e);
    endfunction
    function automatic logic [10:0] dwords_to_4k(input logic [9:0] dw);
        return 11'd1024 - {1'b0, dw};
    endfunction
endpackage

// File: rtl/axi_wdma_if.sv
// axi_wdma_if: AXI4 write channels plus the input AXI-Stream of the write DMA
interface axi_wdma_if #(parameter int ADDRESS_BITS = 32);
    logic [3:0] axi_m_awid;
    logic [ADDRESS_BITS-1:0] axi_m_awaddr;
    logic [7:0] axi_m_awlen;
    logic [2:0] axi_m_awsize;
    logic [1:0] axi_m_awburst;
    logic axi_m_awvalid;
    logic axi_m_awready;
    logic [31:0] axi_m_wdata;
    logic [3:0] axi_m_wstrb;
    logic axi_m_wlast;
    logic axi_m_wvalid;
    logic axi_m_wready;
    logic [3:0] axi_m_bid;
    logic [1:0] axi_m_bresp;
    logic axi_m_bvalid;
    logic axi_m_bready;
    logic [31:0] din_tdata;
    logic [3:0] din_tkeep;
    logic din_tlast;
    logic din_tvalid;
    logic din_tready;
    modport master (
        output axi_m_awid, axi_m_awaddr, axi_m_awlen, axi_m_awsize, axi_m_awburst, axi_m_awvalid,
        output axi_m_wdata, axi_m_wstrb, axi_m_wlast, axi_m_wvalid, axi_m_bready, din_tready,
        input axi_m_awready, axi_m_wready, axi_m_bid, axi_m_bresp, axi_m_bvalid,
        input din_tdata, din_tkeep, din_tlast, din_tvalid
    );
    modport slave (
        input axi_m_awid, axi_m_awaddr, axi_m_awlen, axi_m_awsize, axi_m_awburst, axi_m_awvalid,
        input axi_m_wdata, axi_m_wstrb, axi_m_wlast, axi_m_wvalid, axi_m_bready, din_tready,
        output axi_m_awready, axi_m_wready, axi_m_bid, axi_m_bresp, axi_m_bvalid,
        output din_tdata, din_tkeep, din_tlast, din_tvalid
    );
endinterface

// File: rtl/axi_wdma_strb.sv
// axi_wdma_strb: stream-to-memory byte-lane swap and head/tail/keep strobe generation
module axi_wdma_strb
    import axi_dma_pkg::*;
#(
    parameter bit SWAP = 1'b0,
    parameter bit MEM_BE = 1'b0
) (
    input logic [1:0] off,
    input logic [1:0] eoff,
    input logic first,
    input logic last,
    input logic pad,
    input logic [31:0] tdata,
    input logic [3:0] tkeep,
    output logic [31:0] wdata,
    output logic [3:0] wstrb
);
    logic [3:0] le_mask, mask, keep;
    always_comb begin
        le_mask = (first ? first_mask(off) : 4'b1111) & (last ? last_mask(eoff) : 4'b1111);
        mask = MEM_BE ? {le_mask[0], le_mask[1], le_mask[2], le_mask[3]} : le_mask;
        keep = SWAP ? {tkeep[0], tkeep[1], tkeep[2], tkeep[3]} : tkeep;
        wdata = SWAP ? {tdata[7:0], tdata[15:8], tdata[23:16], tdata[31:24]} : tdata;
        wstrb = pad ? 4'b0000 : mask & keep;
    end
endmodule

// File: rtl/axi_wdma.sv
// axi_wdma: stream-to-memory write DMA issuing 4 KB-safe INCR bursts with head/tail strobes
module axi_wdma
    import axi_dma_pkg::*;
#(
    parameter int ADDRESS_BITS = 32,
    parameter int LENGTH_BITS = 32,
    parameter int MAX_BURST = 256,
    parameter string STREAM_BIG_ENDIAN = "TRUE",
    parameter string MEM_BIG_ENDIAN = "TRUE"
) (
    input logic aclk,
    input logic aresetn,
    input logic [ADDRESS_BITS-1:0] cmd_address,
    input logic [LENGTH_BITS-1:0] cmd_bytes,
    input logic cmd_valid,
    output logic cmd_ready,
    axi_wdma_if.master bus,
    output logic done,
    output logic done_error,
    output logic done_mismatch
);
    localparam bit SWAP = STREAM_BIG_ENDIAN != MEM_BIG_ENDIAN;
    localparam bit MEM_BE = MEM_BIG_ENDIAN == "TRUE";
    state_t state;
    logic [ADDRESS_BITS-1:0] addr;
    logic [LENGTH_BITS-1:0] remaining, total;
    logic [LENGTH_BITS+1:0] len_r;
    logic [10:0] c4k, cap;
    logic [8:0] beats, beat, next_beats;
    logic [1:0] off, eoff;
    logic first, pad, err, mis, err_n, in_w, hs, last_beat, final_dw, unused_bid;
    assign len_r = (LENGTH_BITS+2)'(remaining) + (LENGTH_BITS+2)'(addr[1:0]) + (LENGTH_BITS+2)'(3);
    assign total = remaining == '0 ? '0 : LENGTH_BITS'(len_r >> 2);
    assign c4k = dwords_to_4k(addr[11:2]);
    assign cap = c4k < 11'(MAX_BURST) ? c4k : 11'(MAX_BURST);
    assign next_beats = remaining < LENGTH_BITS'(cap) ? remaining[8:0] : cap[8:0];
    assign in_w = state == S_W;
    assign hs = bus.axi_m_wvalid & bus.axi_m_wready;
    assign last_beat = beat == beats - 9'd1;
    assign final_dw = last_beat && remaining == LENGTH_BITS'(beats);
    assign err_n = err | (bus.axi_m_bresp != RESP_OKAY);
    assign unused_bid = ^bus.axi_m_bid;
    assign bus.axi_m_awid = '0;
    assign bus.axi_m_awsize = SIZE_4B;
    assign bus.axi_m_awburst = BURST_INCR;
    assign bus.axi_m_awaddr = addr;
    assign bus.axi_m_awlen = 8'(beats - 9'd1);
    assign bus.axi_m_wvalid = in_w & (pad | bus.din_tvalid);
    assign bus.din_tready = in_w & ~pad & bus.axi_m_wready;
    assign bus.axi_m_wlast = last_beat;
    axi_wdma_strb #(.SWAP(SWAP), .MEM_BE(MEM_BE)) u_strb (
        .off(off),
        .eoff(eoff),
        .first(first),
        .last(final_dw),
        .pad(pad),
        .tdata(bus.din_tdata),
        .tkeep(bus.din_tkeep),
        .wdata(bus.axi_m_wdata),
        .wstrb(bus.axi_m_wstrb)
    );
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
            cmd_ready <= 1'b1;
            bus.axi_m_awvalid <= 1'b0;
            bus.axi_m_bready <= 1'b0;
            done <= 1'b0;
            done_error <= 1'b0;
            done_mismatch <= 1'b0;
            addr <= '0;
            remaining <= '0;
            beats <= '0;
            beat <= '0;
            off <= '0;
            eoff <= '0;
            first <= 1'b0;
            pad <= 1'b0;
            err <= 1'b0;
            mis <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    addr <= cmd_address;
                    remaining <= cmd_bytes;
                    cmd_ready <= 1'b0;
                    state <= S_INIT;
                end
                S_INIT: begin
                    off <= addr[1:0];
                    eoff <= addr[1:0] + remaining[1:0];
                    addr <= {addr[ADDRESS_BITS-1:2], 2'b00};
                    remaining <= total;
                    first <= 1'b1;
                    pad <= 1'b0;
                    err <= 1'b0;
                    mis <= 1'b0;
                    done <= total == '0;
                    state <= total == '0 ? S_DONE : S_CALC;
                end
                S_CALC: begin
                    beats <= next_beats;
                    beat <= '0;
                    bus.axi_m_awvalid <= 1'b1;
                    state <= S_AW;
                end
                S_AW: if (bus.axi_m_awready) begin
                    bus.axi_m_awvalid <= 1'b0;
                    state <= S_W;
                end
                S_W: if (hs) begin
                    beat <= beat + 9'd1;
                    first <= 1'b0;
                    if (!pad && (bus.din_tlast != final_dw)) mis <= 1'b1;
                    if (!pad && bus.din_tlast && !final_dw) pad <= 1'b1;
                    if (last_beat) begin
                        bus.axi_m_bready <= 1'b1;
                        state <= S_B;
                    end
                end
                S_B: if (bus.axi_m_bvalid) begin
                    bus.axi_m_bready <= 1'b0;
                    err <= err_n;
                    addr <= addr + ADDRESS_BITS'({beats, 2'b00});
                    remaining <= remaining - LENGTH_BITS'(beats);
                    if (remaining == LENGTH_BITS'(beats)) begin
                        done <= 1'b1;
                        done_error <= err_n;
                        done_mismatch <= mis;
                        state <= S_DONE;
                    end else begin
                        state <= S_CALC;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    done_error <= 1'b0;
                    done_mismatch <= 1'b0;
                    err <= 1'b0;
                    mis <= 1'b0;
                    cmd_ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi_wdma.md
Name: axi_wdma

Overview:
Stream-to-memory write DMA and the counterpart of the read DMA. It accepts one (address, byte count) command at a time and consumes 32-bit AXI-Stream words from din. It writes them to memory as incrementing AXI4 bursts, using byte strobes for unaligned heads and tails. It sits between stream producers (capture, decoders) and the AXI interconnect.

Parameters:
ADDRESS_BITS, 32, width of cmd_address and axi_m_awaddr
LENGTH_BITS, 32, width of cmd_bytes and internal dword counters
MAX_BURST, 256, maximum beats per burst (1..256)
STREAM_BIG_ENDIAN, "TRUE", byte order of din_tdata
MEM_BIG_ENDIAN, "TRUE", byte order of memory; byte lanes are swapped when this differs from STREAM_BIG_ENDIAN

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
cmd_address  in  ADDRESS_BITS  start byte address (any alignment)
cmd_bytes  in  LENGTH_BITS  byte count; 0 is a no-op
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high
axi_m_awid  out  4  constant 0
axi_m_awaddr  out  ADDRESS_BITS  burst address, dword aligned
axi_m_awlen  out  8  beats-1
axi_m_awsize  out  3  constant 3'b010
axi_m_awburst  out  2  constant 2'b01 (INCR)
axi_m_awvalid  out  1  address valid
axi_m_awready  in  1  address ready
axi_m_wdata  out  32  write data
axi_m_wstrb  out  4  byte strobes
axi_m_wlast  out  1  last beat of burst
axi_m_wvalid  out  1  data valid
axi_m_wready  in  1  data ready
axi_m_bid  in  4  ignored
axi_m_bresp  in  2  write response
axi_m_bvalid  in  1  response valid
axi_m_bready  out  1  response ready
din_tdata  in  32  stream data; word N maps to memory dword N
din_tkeep  in  4  ANDed into wstrb
din_tlast  in  1  stream end marker
din_tvalid  in  1  stream valid
din_tready  out  1  stream ready
done  out  1  one-cycle pulse when a command completes
done_error  out  1  valid with done: a bresp was non-OKAY
done_mismatch  out  1  valid with done: din_tlast was not on the final dword

Behaviour:
- Reset values: cmd_ready=1, awvalid=0, wvalid=0, bready=0, din_tready=0, done=0, done_error=0, done_mismatch=0, awid=0. Reset mid-transfer abandons the transfer with no completion.
- Dword count: length = cmd_bytes + cmd_address[1:0]; total = ceil(length/4); total = 0 when cmd_bytes = 0.
- First-dword wstrb comes from the address offset: 00→1111, 01→1110, 10→1100, 11→1000.
- Last-dword wstrb comes from (offset + bytes) mod 4: 0→1111, 1→0001, 2→0011, 3→0111.
- When total = 1, wstrb = first AND last mask.
- Mask orientation above is for little-endian memory. For MEM_BIG_ENDIAN, the masks are bit-reversed.
- FSM states: S_IDLE, S_INIT, S_CALC, S_AW, S_W, S_B, S_DONE.
- S_IDLE: cmd_ready=1. Command accept → S_INIT; cmd_ready drops the next cycle.
- S_INIT: latch masks, aligned address and remaining = total. remaining = 0 → S_DONE; otherwise → S_CALC.
- S_CALC: beats = min(remaining, MAX_BURST, dwords left to the next 4 KB boundary). Then → S_AW.
- S_AW: awvalid=1 with awlen = beats-1. On awready → S_W.
- S_W: wvalid follows din_tvalid and din_tready = wready, so a beat moves only when both handshakes complete. wlast is high on beat == beats-1.
- Early din_tlast before the final dword: the remaining beats are issued with wvalid=1, wstrb=0000 and din_tready=0, and the mismatch flag is set.
- Final dword with din_tlast=0: the mismatch flag is set. Words after the final dword are not consumed.
- S_W exits after the wlast handshake → S_B.
- S_B: bready=1. On bvalid, the error flag is ORed with (bresp != 00). Address advances by beats×4 and remaining decreases by beats. remaining > 0 → S_CALC; otherwise → S_DONE.
- S_DONE: done=1 with done_error and done_mismatch for one cycle. Flags then clear → S_IDLE.
- Only one burst is outstanding, with AW before W. Awvalid is held until awready. wdata, wstrb and wlast stay stable while wvalid is high and wready is low.

Decomposition:
- Shared package axi_dma_pkg:
  - FSM state constants.
  - AXI constants: SIZE_4B=3'b010, BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - Function for first/last strobe masks.
  - Function for 4 KB boundary dword count.
- One sub-module, axi_wdma_strb: combinational byte-lane swap and strobe generation (offset, length, beat index, tkeep → wdata, wstrb).

Test Plan:
- addr 0x1000, bytes 16, ready always high → 1 burst, awlen 3, all wstrb 1111, done with no flags.
- addr 0x1003, bytes 2 → total 2, awaddr 0x1000, wstrb 1000 then 0001, awlen 1.
- addr 0x0, bytes 1100, MAX_BURST 256 → total 275, bursts of 256 and 19; second awaddr 0x400.
- addr 0xFF8, bytes 16 → 4 KB split into awlen 1 at 0xFF8 and awlen 1 at 0x1000.
- bytes 16 with din_tlast on word 1 → words 2–3 written with wstrb 0000; done_mismatch=1.
- bresp 2'b10 on first of two bursts → second burst still issued; done_error=1. Also check cmd_bytes 0 → done the cycle after S_INIT with no AW.
